// File: rtl/vroom_onchip_mem_if.sv
// Avalon-MM slave bus bundle for vroom_onchip_mem.
// The master modport drives requests and the slave modport returns read data and stalls.
interface vroom_onchip_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/vroom_onchip_mem.sv
// Parametrised single-clock on-chip RAM with Avalon-MM slave, pipelined reads and post-reset clear.
// Define VROOM_MEM_RDW_BYPASS_EN to forward the previous cycle's write into an adjacent read.
module vroom_onchip_mem #(
  parameter int unsigned        DATA_W         = 32,
  parameter int unsigned        ADDR_W         = 13,
  parameter int unsigned        RD_LAT         = 1,
  parameter int unsigned        CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reset_req,
  input  logic                 clken,
  output logic                 init_busy,
  vroom_onchip_mem_if.slave    bus
);

  localparam int unsigned      DEPTH    = 2 ** ADDR_W;
  localparam int unsigned      NB       = DATA_W / 8;
  localparam logic [ADDR_W:0]  CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W:0]     clr_cnt_q;
  logic                init_busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wait_w;
  logic                accept;
  logic                wr_acc;
  logic                rd_acc;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;
  logic [DATA_W-1:0]   rd_word;

  logic                v1_q;
  logic [DATA_W-1:0]   rd_q;

  assign wait_w          = reset | (state_q != StRun) | ~clken | reset_req;
  assign bus.waitrequest = wait_w;
  assign accept          = bus.chipselect & ~wait_w;
  assign wr_acc          = accept & bus.write;
  // A simultaneous read+write performs only the write.
  assign rd_acc          = accept & bus.read & ~bus.write;
  assign init_busy       = init_busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? StInit : StRun;
      clr_cnt_q   <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else if (clken) begin
      unique case (state_q)
        StInit: begin
          clr_cnt_q <= clr_cnt_q + (ADDR_W + 1)'(1);
          if (clr_cnt_q == CLR_LAST) begin
            state_q     <= StRun;
            init_busy_q <= 1'b0;
          end
        end
        StRun: ;
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    mem_wdata = bus.writedata;
    mem_wbe   = bus.byteenable;
    if (state_q == StInit) begin
      mem_we    = clken & ~reset;
      mem_waddr = clr_cnt_q[ADDR_W-1:0];
      mem_wdata = CLEAR_VALUE;
      mem_wbe   = '1;
    end else begin
      mem_we    = wr_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

`ifdef VROOM_MEM_RDW_BYPASS_EN
  logic                byp_vld_q;
  logic [ADDR_W-1:0]   byp_addr_q;
  logic [NB-1:0]       byp_be_q;
  logic [DATA_W-1:0]   byp_data_q;
  logic                byp_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_vld_q  <= 1'b0;
      byp_addr_q <= '0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else if (clken) begin
      byp_vld_q <= wr_acc;
      if (wr_acc) begin
        byp_addr_q <= bus.address;
        byp_be_q   <= bus.byteenable;
        byp_data_q <= bus.writedata;
      end
    end
  end

  assign byp_hit = byp_vld_q & (byp_addr_q == bus.address);

  always_comb begin
    rd_word = mem[bus.address];
    for (int i = 0; i < int'(NB); i++) begin
      if (byp_hit && byp_be_q[i]) rd_word[8*i +: 8] = byp_data_q[8*i +: 8];
    end
  end
`else
  always_comb begin
    rd_word = mem[bus.address];
  end
`endif

  // First read stage: registered array output plus its valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      rd_q <= '0;
    end else if (clken) begin
      v1_q <= rd_acc;
      if (rd_acc) rd_q <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] rd2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q  <= 1'b0;
        rd2_q <= '0;
      end else if (clken) begin
        v2_q <= v1_q;
        if (v1_q) rd2_q <= rd_q;
      end
    end

    assign bus.readdata      = rd2_q;
    assign bus.readdatavalid = v2_q & clken;
  end else begin : g_lat1
    assign bus.readdata      = rd_q;
    assign bus.readdatavalid = v1_q & clken;
  end

endmodule

// File: tb/tb_vroom_onchip_mem.sv
// Directed bench for vroom_onchip_mem: an RD_LAT=1 and an RD_LAT=2 instance share one stimulus.
module tb_vroom_onchip_mem;

  logic clk = 1'b0;
  logic reset;
  logic reset_req;
  logic clken;
  logic busy1;
  logic busy2;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] CLR = 32'hA5A5A5A5;

  vroom_onchip_mem_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
  vroom_onchip_mem_if #(.DATA_W(32), .ADDR_W(4)) b2 ();

  vroom_onchip_mem #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
  ) u_dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .init_busy(busy1), .bus(b1)
  );

  vroom_onchip_mem #(
    .DATA_W(32), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
  ) u_dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .init_busy(busy2), .bus(b2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;   // 0 write, 1 read, 2 write with chipselect low
    logic [3:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[15];
  logic [3:0]  pa[16];
  logic [31:0] pe[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    b1.chipselect = cs; b1.read = rd; b1.write = wr;
    b1.address = a; b1.byteenable = be; b1.writedata = d;
    b2.chipselect = cs; b2.read = rd; b2.write = wr;
    b2.address = a; b2.byteenable = be; b2.writedata = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d,
                          input string name);
    drv(1'b1, 1'b0, 1'b1, a, be, d);
    #1;
    chk1({name, "_wait"}, b1.waitrequest, 1'b0);
    cycle();
    idle();
    chk1({name, "_nodv1"}, b1.readdatavalid, 1'b0);
    cycle();
    chk1({name, "_nodv2"}, b2.readdatavalid, 1'b0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    drv(1'b1, 1'b1, 1'b0, a, 4'd0, 32'd0);
    #1;
    chk1({name, "_wait"}, b1.waitrequest, 1'b0);
    cycle();
    idle();
    chk1({name, "_dv1"}, b1.readdatavalid, 1'b1);
    chk({name, "_d1"}, b1.readdata, exp);
    chk1({name, "_dv2early"}, b2.readdatavalid, 1'b0);
    cycle();
    chk1({name, "_dv2"}, b2.readdatavalid, 1'b1);
    chk({name, "_d2"}, b2.readdata, exp);
    chk1({name, "_dv1once"}, b1.readdatavalid, 1'b0);
    cycle();
    chk1({name, "_dv2once"}, b2.readdatavalid, 1'b0);
  endtask

  // Back-to-back reads of pa[0..n-1]; both latencies checked every cycle.
  task automatic pipe(input int n, input string name);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drv(1'b1, 1'b1, 1'b0, pa[i], 4'd0, 32'd0);
      else idle();
      cycle();
      if (i < n) begin
        chk1($sformatf("%s_dv1_%0d", name, i), b1.readdatavalid, 1'b1);
        chk($sformatf("%s_d1_%0d", name, i), b1.readdata, pe[i]);
      end else begin
        chk1($sformatf("%s_dv1_%0d", name, i), b1.readdatavalid, 1'b0);
      end
      if (i >= 1 && i <= n) begin
        chk1($sformatf("%s_dv2_%0d", name, i), b2.readdatavalid, 1'b1);
        chk($sformatf("%s_d2_%0d", name, i), b2.readdata, pe[i-1]);
      end else begin
        chk1($sformatf("%s_dv2_%0d", name, i), b2.readdatavalid, 1'b0);
      end
    end
    idle();
  endtask

  task automatic wait_clear(input string name);
    int cnt = 0;
    bit wr_low = 1'b0;
    while ((busy1 || busy2) && cnt < 40) begin
      if (!b1.waitrequest || !b2.waitrequest) wr_low = 1'b1;
      cnt++;
      cycle();
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'd16);
    chk1({name, "_wait_held"}, wr_low, 1'b0);
    chk1({name, "_wait_after"}, b1.waitrequest, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 4'd3,  4'hF, 32'h11223344, 32'h0};
    vecs[1]  = '{0, 4'd3,  4'h2, 32'hFFFFFFFF, 32'h0};
    vecs[2]  = '{1, 4'd3,  4'h0, 32'h0,        32'h1122FF44};
    vecs[3]  = '{0, 4'd7,  4'h5, 32'h12345678, 32'h0};
    vecs[4]  = '{1, 4'd7,  4'h0, 32'h0,        32'hA534A578};
    vecs[5]  = '{0, 4'd8,  4'h8, 32'hCAFEBABE, 32'h0};
    vecs[6]  = '{1, 4'd8,  4'h0, 32'h0,        32'hCAA5A5A5};
    vecs[7]  = '{2, 4'd10, 4'hF, 32'h00000000, 32'h0};
    vecs[8]  = '{1, 4'd10, 4'h0, 32'h0,        32'hA5A5A5A5};
    vecs[9]  = '{0, 4'd15, 4'hF, 32'h0F0F0F0F, 32'h0};
    vecs[10] = '{0, 4'd15, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[11] = '{1, 4'd15, 4'h0, 32'h0,        32'h0F0F0F0F};
    vecs[12] = '{0, 4'd0,  4'hF, 32'h00000001, 32'h0};
    vecs[13] = '{0, 4'd1,  4'hF, 32'h00000002, 32'h0};
    vecs[14] = '{0, 4'd2,  4'hF, 32'h00000003, 32'h0};

    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    cycle(); cycle();
    chk1("rst_dv1", b1.readdatavalid, 1'b0);
    chk1("rst_dv2", b2.readdatavalid, 1'b0);
    chk("rst_rd1", b1.readdata, 32'h0);
    chk("rst_rd2", b2.readdata, 32'h0);
    chk1("rst_wait", b1.waitrequest, 1'b1);
    chk1("rst_busy1", busy1, 1'b1);
    chk1("rst_busy2", busy2, 1'b1);

    reset = 1'b0;
    wait_clear("clr");
    for (int i = 0; i < 16; i++) begin
      pa[i] = 4'(i);
      pe[i] = CLR;
    end
    pipe(16, "clrscan");

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].op == 0) begin
        do_write(vecs[i].a, vecs[i].be, vecs[i].d, $sformatf("vec%0d", i));
      end else if (vecs[i].op == 1) begin
        do_read(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
      end else begin
        drv(1'b0, 1'b0, 1'b1, vecs[i].a, vecs[i].be, vecs[i].d);
        cycle();
        idle();
        cycle();
      end
    end

    pa[0] = 4'd0; pa[1] = 4'd1; pa[2] = 4'd2;
    pe[0] = 32'h1; pe[1] = 32'h2; pe[2] = 32'h3;
    pipe(3, "order");

    // Stall: clken low for three cycles right after an accepted read.
    drv(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 32'd0);
    cycle();
    idle();
    clken = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("stall_wait_%0d", i), b1.waitrequest, 1'b1);
      chk1($sformatf("stall_dv1_%0d", i), b1.readdatavalid, 1'b0);
      chk1($sformatf("stall_dv2_%0d", i), b2.readdatavalid, 1'b0);
      cycle();
    end
    clken = 1'b1;
    #1;
    chk1("stall_dv1_back", b1.readdatavalid, 1'b1);
    chk("stall_d1_back", b1.readdata, 32'h1122FF44);
    chk1("stall_dv2_early", b2.readdatavalid, 1'b0);
    cycle();
    chk1("stall_dv1_once", b1.readdatavalid, 1'b0);
    chk1("stall_dv2_back", b2.readdatavalid, 1'b1);
    chk("stall_d2_back", b2.readdata, 32'h1122FF44);
    cycle();

    // reset_req blocks new accesses but lets in-flight reads finish.
    drv(1'b1, 1'b0, 1'b1, 4'd9, 4'hF, 32'h0);
    reset_req = 1'b1;
    #1;
    chk1("rreq_wait", b1.waitrequest, 1'b1);
    cycle();
    reset_req = 1'b0;
    idle();
    cycle();
    do_read(4'd9, CLR, "rreq_blocked_wr");
    drv(1'b1, 1'b1, 1'b0, 4'd15, 4'd0, 32'd0);
    cycle();
    reset_req = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 32'd0);
    #1;
    chk1("rreq_dv1", b1.readdatavalid, 1'b1);
    chk("rreq_d1", b1.readdata, 32'h0F0F0F0F);
    cycle();
    chk1("rreq_dv2", b2.readdatavalid, 1'b1);
    chk("rreq_d2", b2.readdata, 32'h0F0F0F0F);
    chk1("rreq_dv1_blocked", b1.readdatavalid, 1'b0);
    cycle();
    chk1("rreq_dv2_blocked", b2.readdatavalid, 1'b0);
    reset_req = 1'b0;
    idle();
    cycle();

    // Read and write together: only the write happens.
    drv(1'b1, 1'b1, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF);
    cycle();
`ifdef VROOM_MEM_RDW_BYPASS_EN
    do_read(4'd5, 32'hDEADBEEF, "coll_adj");
`else
    idle();
    chk1("coll_dv1", b1.readdatavalid, 1'b0);
    cycle();
    chk1("coll_dv2", b2.readdatavalid, 1'b0);
    chk1("coll_dv1b", b1.readdatavalid, 1'b0);
    cycle();
    do_read(4'd5, 32'hDEADBEEF, "coll");
`endif

    // Reset during an in-flight read, then again midway through the clear.
    drv(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 32'd0);
    cycle();
    reset = 1'b1;
    idle();
    cycle();
    chk1("rstrd_dv2", b2.readdatavalid, 1'b0);
    chk1("rstrd_dv1", b1.readdatavalid, 1'b0);
    chk1("rstrd_busy", busy1, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk1("midclr_busy_pre", busy1, 1'b1);
    reset = 1'b1;
    cycle();
    chk1("midclr_busy1", busy1, 1'b1);
    chk1("midclr_busy2", busy2, 1'b1);
    chk1("midclr_wait", b1.waitrequest, 1'b1);
    reset = 1'b0;
    wait_clear("reclr");
    do_read(4'd3, CLR, "reclr_w3");
    do_read(4'd15, CLR, "reclr_w15");
    do_read(4'd5, CLR, "reclr_w5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
